riscv_bht_ctrl: RTL and testbench



---
 rtl/riscv_bht_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_riscv_bht_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_bht_ctrl.sv
// riscv_bht_ctrl: 16-entry 2-bit branch history table with lookup/update arbitration,
//   an init/flush sweep and statistic counters for the HPC block.
// Latency: lookup accepted in cycle T -> pred_valid_o/pred_taken_o in T+1; an update is
//   written to the table no earlier than the cycle after it is pushed.
// Backpressure: lookup_ready_o drops only when the update FIFO is full and a lookup is
//   pending (the FIFO head drains that cycle); upd_ready_o = RUN && !full; both low in
//   INIT and in a flush cycle.
// Ports: clk/rst_ni (async active-low); lookup_* (fetch request, ready, 1-cycle prediction);
//   upd_* (resolved branch, valid/ready); flush_i; init_busy_o; stat_* counters.
// Optional: define BHT_UPD_BYPASS_EN to make lookups see pending FIFO updates to their index.
module riscv_bht_ctrl #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned INDEX_LSB  = 2,
  parameter int unsigned UPD_DEPTH  = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             lookup_valid_i,
  input  logic [31:0]      lookup_pc_i,
  output logic             lookup_ready_o,
  output logic             pred_valid_o,
  output logic             pred_taken_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic             upd_ready_o,
  input  logic             flush_i,
  output logic             init_busy_o,
  output logic [CNT_W-1:0] stat_lookup_o,
  output logic [CNT_W-1:0] stat_update_o,
  output logic [CNT_W-1:0] stat_mispred_o
);

  localparam int unsigned N      = 1 << INDEX_BITS;
  localparam int unsigned PTR_W  = $clog2(UPD_DEPTH);
  localparam int unsigned IDX_HI = INDEX_LSB + INDEX_BITS - 1;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef struct packed {
    idx_t idx;
    logic taken;
  } upd_t;
  typedef enum logic {INIT, RUN} state_t;

  // Saturating 2-bit step: taken moves toward 00, not-taken toward 11.
  function automatic logic [1:0] sat_step(input logic [1:0] e, input logic taken);
    if (taken) return (e == 2'b00) ? 2'b00 : e - 2'b01;
    else       return (e == 2'b11) ? 2'b11 : e + 2'b01;
  endfunction

  state_t           state_q, state_d;
  idx_t             sweep_q, sweep_d;
  logic [1:0]       bht_q [N];
  upd_t             fifo_q [UPD_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full, empty;
  idx_t             lk_idx, up_idx;
  upd_t             head;
  logic             lk_rdy, up_rdy, lk_acc, up_acc, pop, fifo_clr;
  logic             tbl_we;
  idx_t             tbl_widx;
  logic [1:0]       tbl_wdat;
  logic [1:0]       pred_ent;
  logic             pred_valid_q, pred_taken_q;
  logic [CNT_W-1:0] stat_lookup_q, stat_update_q, stat_mispred_q;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc_i[IDX_HI:INDEX_LSB];
  assign up_idx = upd_pc_i[IDX_HI:INDEX_LSB];
  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_HI+1], lookup_pc_i[INDEX_LSB-1:0],
                            upd_pc_i[31:IDX_HI+1], upd_pc_i[INDEX_LSB-1:0]};

  assign full  = (cnt_q == (PTR_W+1)'(UPD_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // Next-state and table-port arbitration. The table has one port: the
  // sweep write, a lookup read, or a FIFO-head read-modify-write.
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    lk_rdy   = 1'b0;
    up_rdy   = 1'b0;
    pop      = 1'b0;
    fifo_clr = 1'b0;
    tbl_we   = 1'b0;
    tbl_widx = sweep_q;
    tbl_wdat = 2'b10;
    case (state_q)
      INIT: begin
        tbl_we  = 1'b1;
        sweep_d = sweep_q + idx_t'(1);
        if (sweep_q == idx_t'(N-1)) state_d = RUN;
      end
      RUN: begin
        if (flush_i) begin
          fifo_clr = 1'b1;
          sweep_d  = '0;
          state_d  = INIT;
        end else begin
          // A full FIFO steals the port from a pending lookup so updates
          // cannot starve behind continuous fetch traffic.
          lk_rdy = !(full && lookup_valid_i);
          up_rdy = !full;
          if (!(lookup_valid_i && lk_rdy) && !empty) begin
            pop      = 1'b1;
            tbl_we   = 1'b1;
            tbl_widx = head.idx;
            tbl_wdat = sat_step(bht_q[head.idx], head.taken);
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign lk_acc = lookup_valid_i && lk_rdy;
  assign up_acc = upd_valid_i && up_rdy;

  always_comb begin
    cnt_d = cnt_q;
    case ({up_acc, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Prediction source; with bypass, pending updates to the same index are
  // folded in oldest-first on top of the stored entry.
  always_comb begin
    pred_ent = bht_q[lk_idx];
`ifdef BHT_UPD_BYPASS_EN
    for (int i = 0; i < UPD_DEPTH; i++) begin
      logic [PTR_W-1:0] slot;
      slot = rd_ptr_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < cnt_q) && (fifo_q[slot].idx == lk_idx))
        pred_ent = sat_step(pred_ent, fifo_q[slot].taken);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= INIT;
      sweep_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      cnt_q          <= '0;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      stat_lookup_q  <= '0;
      stat_update_q  <= '0;
      stat_mispred_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      pred_valid_q <= lk_acc;
      if (lk_acc) pred_taken_q <= !pred_ent[1];
      if (fifo_clr) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (up_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_d;
      end
      if (lk_acc) stat_lookup_q <= stat_lookup_q + CNT_W'(1);
      if (up_acc) stat_update_q <= stat_update_q + CNT_W'(1);
      if (up_acc && (upd_taken_i != upd_pred_i)) stat_mispred_q <= stat_mispred_q + CNT_W'(1);
    end
  end

  // Storage needs no reset: the table is rewritten by the sweep and FIFO
  // slots are only read when counted as occupied.
  always_ff @(posedge clk) begin
    if (up_acc) fifo_q[wr_ptr_q] <= '{idx: up_idx, taken: upd_taken_i};
    if (tbl_we) bht_q[tbl_widx] <= tbl_wdat;
  end

  assign lookup_ready_o = lk_rdy;
  assign upd_ready_o    = up_rdy;
  assign pred_valid_o   = pred_valid_q;
  assign pred_taken_o   = pred_taken_q;
  assign init_busy_o    = (state_q == INIT);
  assign stat_lookup_o  = stat_lookup_q;
  assign stat_update_o  = stat_update_q;
  assign stat_mispred_o = stat_mispred_q;

endmodule

// File: tb/tb_riscv_bht_ctrl.sv
// Testbench for riscv_bht_ctrl: vector table, hand sequences and a random run
// compared against a queue-based reference model of the table and update FIFO.
module tb_riscv_bht_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        lookup_ready_o;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_pred_i;
  logic        upd_ready_o;
  logic        flush_i;
  logic        init_busy_o;
  logic [31:0] stat_lookup_o, stat_update_o, stat_mispred_o;

  always #5 clk = ~clk;

  riscv_bht_ctrl dut (
    .clk(clk), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i), .lookup_ready_o(lookup_ready_o),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_pred_i(upd_pred_i), .upd_ready_o(upd_ready_o),
    .flush_i(flush_i), .init_busy_o(init_busy_o),
    .stat_lookup_o(stat_lookup_o), .stat_update_o(stat_update_o), .stat_mispred_o(stat_mispred_o)
  );

`ifdef BHT_UPD_BYPASS_EN
  localparam bit BYP_EXP = 1'b1;
`else
  localparam bit BYP_EXP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: table as int array, pending updates as a queue.
  typedef struct { int idx; bit taken; } pend_t;
  int          m_tbl [16];
  pend_t       m_q [$];
  bit          m_init;
  int          m_sweep;
  int unsigned m_lk, m_up, m_mis;
  bit          m_pv, m_pt;

  logic obs_lr, obs_ur, obs_busy, obs_pv, obs_pt;

  typedef struct {
    bit lv; logic [31:0] lpc; bit uv; logic [31:0] upc; bit ut; bit up;
    bit exp_lr; bit exp_ur; bit exp_pv; bit exp_pt;
  } vec_t;
  vec_t vt [16];

  function automatic int sat(int e, bit t);
    if (t) return (e > 0) ? e - 1 : 0;
    return (e < 3) ? e + 1 : 3;
  endfunction

  function automatic int pidx(logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic vec_t mk(bit lv, logic [31:0] lpc, bit uv, logic [31:0] upc, bit ut, bit up,
                              bit lr, bit ur, bit pv, bit pt);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.up = up;
    v.exp_lr = lr; v.exp_ur = ur; v.exp_pv = pv; v.exp_pt = pt;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_sweep = 0; m_q.delete();
    m_lk = 0; m_up = 0; m_mis = 0; m_pv = 1'b0; m_pt = 1'b0;
  endtask

  // One clock: drive at posedge+1, check ready/busy mid-cycle, advance the
  // model, then check registered outputs at the next posedge+1.
  task automatic cycle(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                       input bit ut, input bit up, input bit fl);
    bit elr, eur, full, lacc, uacc;
    int e;
    pend_t h;
    lookup_valid_i = lv; lookup_pc_i = lpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_pred_i = up;
    flush_i = fl;
    #3;
    full = (m_q.size() == 2);
    elr  = !m_init && !fl && !(full && lv);
    eur  = !m_init && !fl && !full;
    obs_lr = lookup_ready_o; obs_ur = upd_ready_o; obs_busy = init_busy_o;
    chk("lookup_ready", obs_lr, elr);
    chk("upd_ready", obs_ur, eur);
    chk("init_busy", obs_busy, m_init);
    lacc = lv && elr;
    uacc = uv && eur;
    m_pv = 1'b0;
    if (m_init) begin
      m_tbl[m_sweep] = 2;
      m_sweep++;
      if (m_sweep == 16) m_init = 1'b0;
    end else if (fl) begin
      m_q.delete();
      m_init = 1'b1;
      m_sweep = 0;
    end else begin
      if (lacc) begin
        e = m_tbl[pidx(lpc)];
`ifdef BHT_UPD_BYPASS_EN
        foreach (m_q[i]) if (m_q[i].idx == pidx(lpc)) e = sat(e, m_q[i].taken);
`endif
        m_pv = 1'b1;
        m_pt = (e < 2);
        m_lk++;
      end else if (m_q.size() > 0) begin
        h = m_q.pop_front();
        m_tbl[h.idx] = sat(m_tbl[h.idx], h.taken);
      end
      if (uacc) begin
        m_q.push_back('{idx: pidx(upc), taken: ut});
        m_up++;
        if (ut != up) m_mis++;
      end
    end
    @(posedge clk); #1;
    obs_pv = pred_valid_o; obs_pt = pred_taken_o;
    chk("pred_valid", obs_pv, m_pv);
    chk("pred_taken", obs_pt, m_pt);
    chk("stat_lookup", stat_lookup_o, m_lk);
    chk("stat_update", stat_update_o, m_up);
    chk("stat_mispred", stat_mispred_o, m_mis);
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    lookup_valid_i = 1'b0; lookup_pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0;
    upd_taken_i = 1'b0; upd_pred_i = 1'b0; flush_i = 1'b0;
    model_reset();
    #3;
    chk("rst lookup_ready", lookup_ready_o, 0);
    chk("rst upd_ready", upd_ready_o, 0);
    chk("rst pred_valid", pred_valid_o, 0);
    chk("rst pred_taken", pred_taken_o, 0);
    chk("rst init_busy", init_busy_o, 1);
    chk("rst stats", stat_lookup_o | stat_update_o | stat_mispred_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  // Counts consecutive busy cycles; bounded so a stuck sweep still ends.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (!obs_busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] lpc, upc;

    vt[0]  = mk(0, 32'h0,  1, 32'h24, 1, 0,  1, 1, 0, 0);
    vt[1]  = mk(0, 32'h0,  1, 32'h24, 1, 1,  1, 1, 0, 0);
    vt[2]  = mk(0, 32'h0,  1, 32'h24, 1, 0,  1, 1, 0, 0);
    vt[3]  = mk(0, 32'h0,  0, 32'h0,  0, 0,  1, 1, 0, 0);
    vt[4]  = mk(1, 32'h24, 0, 32'h0,  0, 0,  1, 1, 1, 1);
    vt[5]  = mk(0, 32'h0,  1, 32'h24, 1, 1,  1, 1, 0, 1);
    vt[6]  = mk(0, 32'h0,  0, 32'h0,  0, 0,  1, 1, 0, 1);
    vt[7]  = mk(0, 32'h0,  1, 32'h24, 0, 1,  1, 1, 0, 1);
    vt[8]  = mk(0, 32'h0,  1, 32'h24, 0, 0,  1, 1, 0, 1);
    vt[9]  = mk(0, 32'h0,  1, 32'h24, 0, 1,  1, 1, 0, 1);
    vt[10] = mk(0, 32'h0,  1, 32'h24, 0, 0,  1, 1, 0, 1);
    vt[11] = mk(0, 32'h0,  0, 32'h0,  0, 0,  1, 1, 0, 1);
    vt[12] = mk(1, 32'h24, 0, 32'h0,  0, 0,  1, 1, 1, 0);
    vt[13] = mk(0, 32'h0,  1, 32'h24, 0, 0,  1, 1, 0, 0);
    vt[14] = mk(0, 32'h0,  0, 32'h0,  0, 0,  1, 1, 0, 0);
    vt[15] = mk(1, 32'h24, 0, 32'h0,  0, 0,  1, 1, 1, 0);

    // Reset, sweep length, first lookup.
    do_reset();
    count_busy(n);
    chk("init sweep cycles", n, 16);
    chk("post-init stat_lookup", stat_lookup_o, 0);
    chk("post-init stat_update", stat_update_o, 0);
    cycle(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("first pred_valid", obs_pv, 1);
    chk("first pred_taken", obs_pt, 0);

    // Pending update visibility to an immediate lookup.
    cycle(1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bypass pred_taken", obs_pt, BYP_EXP);
    idle(); idle();

    // Misprediction counting from a clean reset.
    do_reset();
    count_busy(n);
    chk("reinit sweep cycles", n, 16);
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    chk("mispred stat_update", stat_update_o, 3);
    chk("mispred stat_mispred", stat_mispred_o, 2);
    chk("mispred stat_lookup", stat_lookup_o, 0);

    // Flush with a pending update: nothing accepted, table re-swept, stats kept.
    cycle(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
    chk("flush lookup_ready", obs_lr, 0);
    chk("flush upd_ready", obs_ur, 0);
    count_busy(n);
    chk("flush sweep cycles", n, 16);
    chk("flush stat_update", stat_update_o, 4);
    chk("flush stat_mispred", stat_mispred_o, 2);
    chk("flush stat_lookup", stat_lookup_o, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'(i) << 2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("flushed entry %0d valid", i), obs_pv, 1);
      chk($sformatf("flushed entry %0d taken", i), obs_pt, 0);
    end

    // Saturation vectors on index 9.
    for (int i = 0; i < 16; i++) begin
      cycle(vt[i].lv, vt[i].lpc, vt[i].uv, vt[i].upc, vt[i].ut, vt[i].up, 1'b0);
      chk($sformatf("vec%0d lookup_ready", i), obs_lr, vt[i].exp_lr);
      chk($sformatf("vec%0d upd_ready", i), obs_ur, vt[i].exp_ur);
      chk($sformatf("vec%0d pred_valid", i), obs_pv, vt[i].exp_pv);
      chk($sformatf("vec%0d pred_taken", i), obs_pt, vt[i].exp_pt);
    end

    // Continuous lookups with updates offered: FIFO fills, steals one lookup slot.
    cycle(1'b1, 32'h100, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
    chk("bp A lookup_ready", obs_lr, 1); chk("bp A upd_ready", obs_ur, 1);
    cycle(1'b1, 32'h100, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
    chk("bp B lookup_ready", obs_lr, 1); chk("bp B upd_ready", obs_ur, 1);
    cycle(1'b1, 32'h100, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
    chk("bp C lookup_ready", obs_lr, 0); chk("bp C upd_ready", obs_ur, 0);
    cycle(1'b1, 32'h100, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0);
    chk("bp D lookup_ready", obs_lr, 1); chk("bp D upd_ready", obs_ur, 1);
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bp E lookup_ready", obs_lr, 0);
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("bp F lookup_ready", obs_lr, 1);
    idle(); idle(); idle();

    // Reset in the middle of the sweep.
    do_reset();
    repeat (7) idle();
    chk("mid-sweep busy", obs_busy, 1);
    do_reset();
    count_busy(n);
    chk("restarted sweep cycles", n, 16);

    // Random traffic with index collisions and occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      lpc = ($urandom & ~32'h3C) | (32'($urandom_range(0, 3)) << 2);
      upc = ($urandom & ~32'h3C) | (32'($urandom_range(0, 3)) << 2);
      cycle(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
